ncc_corr_engine: RTL and testbench
==================================

Name: ncc_corr_engine

Overview:
- Parametrised successor to the fixed 16x16 descriptor/window correlator: a GRID x GRID correlation engine in the linear domain.
- Loads a signed descriptor through a valid/ready stream and stores it locally.
- Then streams unsigned window pixels, multiply-accumulates each against the stored descriptor, and emits one saturated score per window through a valid/ready output.
- Sits between the descriptor fetch path and the match/peak-select logic in the vision pipeline.

Parameters:
GRID, 16, descriptor/window side length; GRID*GRID pixels per descriptor and per window
PIX_W, 8, bits per pixel; descriptor is signed two's complement, window is unsigned
PACK, 4, pixels per input beat; GRID*GRID must be divisible by PACK (elaboration error otherwise)
ACC_W, 24, signed score width; the accumulator saturates at this width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
desc_valid  in  1  descriptor beat valid
desc_data  in  PACK*PIX_W  descriptor pixels, lowest-index pixel in the MS slice
desc_ready  out  1  engine accepts a descriptor beat
reload_desc  in  1  request a new descriptor load
win_valid  in  1  window beat valid
win_data  in  PACK*PIX_W  window pixels, same packing as desc_data
win_ready  out  1  engine accepts a window beat
score_valid  out  1  score available
score  out  ACC_W  signed correlation sum for the window
score_sat  out  1  saturation occurred during this window
score_ready  in  1  downstream accepts the score
desc_loaded  out  1  a complete descriptor is held

Behaviour:
- Reset is synchronous and active-high. Every state register is cleared: state=DESC_LOAD, beat counter=0, acc=0, score=0, score_sat=0, score_valid=0, desc_loaded=0. Descriptor storage is cleared to 0.
- Handshake: a beat transfers on a cycle where valid&&ready are both high at the rising edge. Valid-side data must be held until the transfer.
- Beat counter: counts 0..BEATS-1, where BEATS=GRID*GRID/PACK. Pixel index for a beat = beat*PACK+k, row-major.
- DESC_LOAD state:
  - desc_ready=1, win_ready=0.
  - Each transfer writes PACK descriptor entries.
  - On the final beat transfer: counter wraps to 0, desc_loaded=1, next state WIN_ACC.
- WIN_ACC state:
  - win_ready=1, desc_ready=0.
  - On transfer: beat_sum = sum over k of signed(desc[idx]) * unsigned(win[k]), computed at full width with no truncation.
  - acc <= sat_ACC_W(acc + beat_sum). Any clamp sets sticky sat_flag.
  - On the final beat: score <= that same saturated value, score_sat <= sat_flag including this beat, score_valid=1 from the next cycle, state SCORE_OUT.
  - Latency is one cycle from the final window beat to score_valid.
- SCORE_OUT state:
  - win_ready=0; score, score_sat and score_valid are held stable.
  - On score_ready: score_valid=0, acc=0, sat_flag=0, counter=0.
  - Next state is DESC_LOAD if reload_pending, otherwise WIN_ACC.
- reload_desc handling:
  - Sampled in any state and latched into reload_pending, which clears on entry to DESC_LOAD.
  - In WIN_ACC with counter=0 and no transfer this cycle: go to DESC_LOAD next cycle.
  - Mid-window (counter>0): the current window completes first.
  - desc_loaded=0 while in DESC_LOAD after a reload.
- Saturation clamps to +(2^(ACC_W-1)-1) and -(2^(ACC_W-1)).
- Simultaneous events:
  - win_valid during DESC_LOAD or SCORE_OUT is ignored and no data is consumed.
  - desc_valid outside DESC_LOAD is ignored.
  - reload_desc in the same cycle as a score handshake takes effect on that transition.
- Reset asserted mid-window or mid-load aborts the operation; no score is emitted.

Test Plan:
1. Reset check (GRID=4, PACK=4, PIX_W=8, ACC_W=16): hold rst 2 cycles -> desc_ready=1, win_ready=0, score_valid=0, score=0, desc_loaded=0.
2. Basic score: load 4 beats of descriptor all +1; window pixels 0..15 -> score_valid one cycle after the 4th window beat; score=120, score_sat=0.
3. Signed case: descriptor all -1 (0xFF), window all 255 -> score=-4080.
4. Saturation: descriptor all 127, window all 255 (true sum 518160) -> score=32767, score_sat=1. The next window of all 0 -> score=0, score_sat=0.
5. Backpressure: hold score_ready=0 for 5 cycles with win_valid=1 -> score held, win_ready=0, no window beat consumed. Release -> the next window starts the following cycle and its score is correct.
6. Reload and reset mid-operation:
   - Assert reload_desc after window beat 2 -> the window finishes, its score is accepted, then state is DESC_LOAD and a new descriptor (all +2) gives score=240 on window 0..15.
   - Assert rst after window beat 1 -> no score, state DESC_LOAD.

Source files
------------

// File: rtl/ncc_corr_engine.sv
// GRID x GRID linear-domain correlation engine: stores a signed descriptor, then
// multiply-accumulates unsigned window pixels against it and emits one saturated score per window.
module ncc_corr_engine #(
    parameter int GRID  = 16,
    parameter int PIX_W = 8,
    parameter int PACK  = 4,
    parameter int ACC_W = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  desc_valid,
    input  logic [PACK*PIX_W-1:0] desc_data,
    output logic                  desc_ready,
    input  logic                  reload_desc,
    input  logic                  win_valid,
    input  logic [PACK*PIX_W-1:0] win_data,
    output logic                  win_ready,
    output logic                  score_valid,
    output logic [ACC_W-1:0]      score,
    output logic                  score_sat,
    input  logic                  score_ready,
    output logic                  desc_loaded
);

    // Handshakes: a beat or score transfers on a rising edge where valid && ready are
    // both high; the valid side holds its data stable until that edge.

    localparam int PIXELS = GRID * GRID;
    localparam int BEATS  = PIXELS / PACK;
    localparam int BEAT_W = PACK * PIX_W;
    localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int SUM_W  = 2 * PIX_W + 2 + $clog2(PACK);
    localparam int EXT_W  = ((ACC_W > SUM_W) ? ACC_W : SUM_W) + 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    generate
        if (PIXELS % PACK != 0) begin : g_bad_pack
            $error("ncc_corr_engine: GRID*GRID must be divisible by PACK");
        end
    endgenerate

    typedef enum logic [1:0] {
        DESC_LOAD = 2'd0,
        WIN_ACC   = 2'd1,
        SCORE_OUT = 2'd2
    } state_e;

    state_e                       state_q, state_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic [ACC_W-1:0]             acc_q, acc_d;
    logic                         sat_q, sat_d;
    logic [ACC_W-1:0]             score_q, score_d;
    logic                         score_sat_q, score_sat_d;
    logic                         score_valid_q, score_valid_d;
    logic                         desc_loaded_q, desc_loaded_d;
    logic                         reload_pending_q, reload_pending_d;
    logic                         desc_ready_q, desc_ready_d;
    logic                         win_ready_q, win_ready_d;
    logic [BEATS-1:0][BEAT_W-1:0] desc_q, desc_d;

    logic [BEAT_W-1:0] desc_word;
    logic [SUM_W-1:0]  beat_sum;
    logic [EXT_W-1:0]  sum_ext;
    logic              overflow;
    logic [ACC_W-1:0]  acc_next;

    // Descriptor storage keeps whole beats, so the word for the current beat lines up
    // pixel-for-pixel with the incoming window beat.
    always_comb begin : p_mac
        logic [PIX_W-1:0] d_pix;
        logic [PIX_W-1:0] w_pix;
        logic [SUM_W-1:0] d_ext;
        logic [SUM_W-1:0] w_ext;
        desc_word = desc_q[cnt_q];
        beat_sum  = '0;
        d_pix     = '0;
        w_pix     = '0;
        d_ext     = '0;
        w_ext     = '0;
        for (int k = 0; k < PACK; k++) begin
            d_pix    = desc_word[(PACK-1-k)*PIX_W +: PIX_W];
            w_pix    = win_data[(PACK-1-k)*PIX_W +: PIX_W];
            d_ext    = {{(SUM_W-PIX_W){d_pix[PIX_W-1]}}, d_pix};
            w_ext    = {{(SUM_W-PIX_W){1'b0}}, w_pix};
            beat_sum = beat_sum + d_ext * w_ext;
        end
        sum_ext  = {{(EXT_W-ACC_W){acc_q[ACC_W-1]}}, acc_q}
                 + {{(EXT_W-SUM_W){beat_sum[SUM_W-1]}}, beat_sum};
        // Any disagreement among the bits above the ACC_W sign bit means the value left range.
        overflow = (sum_ext[EXT_W-1:ACC_W-1] != {(EXT_W-ACC_W+1){sum_ext[EXT_W-1]}});
        if (!overflow) begin
            acc_next = sum_ext[ACC_W-1:0];
        end else if (sum_ext[EXT_W-1]) begin
            acc_next = {1'b1, {(ACC_W-1){1'b0}}};
        end else begin
            acc_next = {1'b0, {(ACC_W-1){1'b1}}};
        end
    end

    always_comb begin : p_ctrl
        logic desc_fire;
        logic win_fire;
        logic score_fire;
        logic last_beat;
        logic reload_req;
        desc_fire  = desc_valid && (state_q == DESC_LOAD);
        win_fire   = win_valid && (state_q == WIN_ACC);
        score_fire = score_valid_q && score_ready;
        last_beat  = (cnt_q == LAST_BEAT);
        reload_req = reload_pending_q || reload_desc;

        state_d          = state_q;
        cnt_d            = cnt_q;
        acc_d            = acc_q;
        sat_d            = sat_q;
        score_d          = score_q;
        score_sat_d      = score_sat_q;
        score_valid_d    = score_valid_q;
        desc_loaded_d    = desc_loaded_q;
        reload_pending_d = reload_req;
        desc_d           = desc_q;

        case (state_q)
            DESC_LOAD: begin
                if (desc_fire) begin
                    desc_d[cnt_q] = desc_data;
                    if (last_beat) begin
                        cnt_d         = '0;
                        desc_loaded_d = 1'b1;
                        state_d       = WIN_ACC;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            WIN_ACC: begin
                if (win_fire) begin
                    acc_d = acc_next;
                    sat_d = sat_q | overflow;
                    if (last_beat) begin
                        cnt_d         = '0;
                        score_d       = acc_next;
                        score_sat_d   = sat_q | overflow;
                        score_valid_d = 1'b1;
                        state_d       = SCORE_OUT;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if ((cnt_q == '0) && reload_req) begin
                    state_d          = DESC_LOAD;
                    reload_pending_d = 1'b0;
                    desc_loaded_d    = 1'b0;
                end
            end
            SCORE_OUT: begin
                if (score_fire) begin
                    score_valid_d = 1'b0;
                    acc_d         = '0;
                    sat_d         = 1'b0;
                    cnt_d         = '0;
                    if (reload_req) begin
                        state_d          = DESC_LOAD;
                        reload_pending_d = 1'b0;
                        desc_loaded_d    = 1'b0;
                    end else begin
                        state_d = WIN_ACC;
                    end
                end
            end
            default: begin
                state_d = DESC_LOAD;
            end
        endcase

        desc_ready_d = (state_d == DESC_LOAD);
        win_ready_d  = (state_d == WIN_ACC);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= DESC_LOAD;
            cnt_q            <= '0;
            acc_q            <= '0;
            sat_q            <= 1'b0;
            score_q          <= '0;
            score_sat_q      <= 1'b0;
            score_valid_q    <= 1'b0;
            desc_loaded_q    <= 1'b0;
            reload_pending_q <= 1'b0;
            desc_ready_q     <= 1'b1;
            win_ready_q      <= 1'b0;
            desc_q           <= '0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            acc_q            <= acc_d;
            sat_q            <= sat_d;
            score_q          <= score_d;
            score_sat_q      <= score_sat_d;
            score_valid_q    <= score_valid_d;
            desc_loaded_q    <= desc_loaded_d;
            reload_pending_q <= reload_pending_d;
            desc_ready_q     <= desc_ready_d;
            win_ready_q      <= win_ready_d;
            desc_q           <= desc_d;
        end
    end

    assign desc_ready  = desc_ready_q;
    assign win_ready   = win_ready_q;
    assign score_valid = score_valid_q;
    assign score       = score_q;
    assign score_sat   = score_sat_q;
    assign desc_loaded = desc_loaded_q;

endmodule

// File: tb/tb_ncc_corr_engine.sv
// Bench for ncc_corr_engine at GRID=4, PACK=4, PIX_W=8, ACC_W=16: directed cases plus
// randomized descriptors/windows against a plain-arithmetic reference, checked by a score monitor.
module tb_ncc_corr_engine;
    localparam int GRID  = 4;
    localparam int PIX_W = 8;
    localparam int PACK  = 4;
    localparam int ACC_W = 16;
    localparam int NPIX  = GRID * GRID;
    localparam int BEATS = NPIX / PACK;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  desc_valid = 1'b0;
    logic [PACK*PIX_W-1:0] desc_data = '0;
    logic                  desc_ready;
    logic                  reload_desc = 1'b0;
    logic                  win_valid = 1'b0;
    logic [PACK*PIX_W-1:0] win_data = '0;
    logic                  win_ready;
    logic                  score_valid;
    logic [ACC_W-1:0]      score;
    logic                  score_sat;
    logic                  score_ready = 1'b1;
    logic                  desc_loaded;

    int n_checks = 0;
    int n_fail   = 0;
    logic [ACC_W:0] exp_q[$];
    int desc_val[NPIX];
    int ref_desc[NPIX];
    int win_val[NPIX];
    int ready_pct = 100;

    ncc_corr_engine #(.GRID(GRID), .PIX_W(PIX_W), .PACK(PACK), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst(rst),
        .desc_valid(desc_valid), .desc_data(desc_data), .desc_ready(desc_ready),
        .reload_desc(reload_desc),
        .win_valid(win_valid), .win_data(win_data), .win_ready(win_ready),
        .score_valid(score_valid), .score(score), .score_sat(score_sat),
        .score_ready(score_ready), .desc_loaded(desc_loaded)
    );

    // clock / reset
    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        score_ready = ($urandom_range(0, 99) < ready_pct);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: per-beat partial sums accumulated with clamping and a sticky flag.
    function automatic logic [ACC_W:0] model_score();
        longint acc;
        longint bs;
        longint maxv;
        longint minv;
        bit     sat;
        maxv = (longint'(1) << (ACC_W - 1)) - 1;
        minv = -(longint'(1) << (ACC_W - 1));
        acc  = 0;
        sat  = 0;
        for (int b = 0; b < BEATS; b++) begin
            bs = 0;
            for (int k = 0; k < PACK; k++)
                bs += longint'(ref_desc[b*PACK+k]) * longint'(win_val[b*PACK+k]);
            acc += bs;
            if (acc > maxv) begin acc = maxv; sat = 1; end
            else if (acc < minv) begin acc = minv; sat = 1; end
        end
        return {sat, acc[ACC_W-1:0]};
    endfunction

    function automatic logic [PACK*PIX_W-1:0] pack_beat(input bit is_desc, input int b);
        logic [PACK*PIX_W-1:0] w;
        int v;
        w = '0;
        for (int k = 0; k < PACK; k++) begin
            v = is_desc ? desc_val[b*PACK+k] : win_val[b*PACK+k];
            w[(PACK-1-k)*PIX_W +: PIX_W] = v[PIX_W-1:0];
        end
        return w;
    endfunction

    // driver tasks: entered and left at posedge+1
    task automatic send_desc();
        int n;
        ref_desc = desc_val;
        for (int b = 0; b < BEATS; b++) begin
            desc_data  = pack_beat(1'b1, b);
            desc_valid = 1'b1;
            n = 0;
            @(negedge clk);
            while (!desc_ready && n < 300) begin @(negedge clk); n++; end
            if (!desc_ready) begin
                check("desc_ready timeout", desc_ready, 1);
                desc_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        desc_valid = 1'b0;
        @(negedge clk);
        check("desc_loaded after load", desc_loaded, 1);
        @(posedge clk); #1;
    endtask

    task automatic drive_win_beat(input int b, output bit ok);
        int n;
        win_data  = pack_beat(1'b0, b);
        win_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!win_ready && n < 300) begin @(negedge clk); n++; end
        ok = win_ready;
        if (!ok) begin
            check("win_ready timeout", win_ready, 1);
            win_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        win_valid = 1'b0;
    endtask

    task automatic send_win(input int reload_at, input int max_gap);
        bit ok;
        exp_q.push_back(model_score());
        for (int b = 0; b < BEATS; b++) begin
            repeat ($urandom_range(0, max_gap)) begin @(posedge clk); #1; end
            drive_win_beat(b, ok);
            if (!ok) return;
            if (b == reload_at) begin
                reload_desc = 1'b1;
                @(posedge clk); #1;
                reload_desc = 1'b0;
            end
        end
        @(negedge clk);
        check("score_valid one cycle after last beat", score_valid, 1);
        @(posedge clk); #1;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || score_valid) && n < 500) begin @(negedge clk); n++; end
        check("expected queue drained", exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic do_reload();
        reload_desc = 1'b1;
        @(posedge clk); #1;
        reload_desc = 1'b0;
        @(negedge clk);
        check("reload -> desc_ready", desc_ready, 1);
        check("reload -> desc_loaded cleared", desc_loaded, 0);
        @(posedge clk); #1;
    endtask

    // scoreboard monitor
    bit             hold_v = 0;
    logic [ACC_W:0] hold_val;
    logic [ACC_W:0] exp_e;

    always @(negedge clk) begin
        if (rst) begin
            hold_v = 0;
        end else begin
            if (hold_v) begin
                check("score_valid held", score_valid, 1);
                check("score held stable", {score_sat, score}, hold_val);
            end
            if (score_valid && score_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected score_valid", score_valid, 0);
                end else begin
                    exp_e = exp_q.pop_front();
                    check("score", score, exp_e[ACC_W-1:0]);
                    check("score_sat", score_sat, exp_e[ACC_W]);
                end
                hold_v = 0;
            end else if (score_valid) begin
                hold_v   = 1;
                hold_val = {score_sat, score};
            end else begin
                hold_v = 0;
            end
        end
    end

    initial begin
        logic [ACC_W:0] exp_a;
        bit ok;

        // reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset desc_ready", desc_ready, 1);
        check("reset win_ready", win_ready, 0);
        check("reset score_valid", score_valid, 0);
        check("reset score", score, 0);
        check("reset desc_loaded", desc_loaded, 0);
        @(posedge clk); #1;

        // basic: descriptor +1, window 0..15
        foreach (desc_val[i]) desc_val[i] = 1;
        send_desc();
        foreach (win_val[i]) win_val[i] = i;
        send_win(-1, 0);
        wait_drain();

        // signed: descriptor -1, window 255
        do_reload();
        foreach (desc_val[i]) desc_val[i] = -1;
        send_desc();
        foreach (win_val[i]) win_val[i] = 255;
        send_win(-1, 0);
        wait_drain();

        // saturation then clean window
        do_reload();
        foreach (desc_val[i]) desc_val[i] = 127;
        send_desc();
        foreach (win_val[i]) win_val[i] = 255;
        send_win(-1, 0);
        foreach (win_val[i]) win_val[i] = 0;
        send_win(-1, 0);
        wait_drain();

        // backpressure: score held, window beats refused
        foreach (win_val[i]) win_val[i] = $urandom_range(0, 63);
        exp_a = model_score();
        ready_pct = 0;
        send_win(-1, 0);
        foreach (win_val[i]) win_val[i] = $urandom_range(0, 255);
        win_data  = pack_beat(1'b0, 0);
        win_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("backpressure win_ready", win_ready, 0);
            check("backpressure score", {score_sat, score}, exp_a);
        end
        win_valid = 1'b0;
        ready_pct = 100;
        begin
            int n;
            n = 0;
            @(negedge clk);
            while (!(score_valid && score_ready) && n < 50) begin @(negedge clk); n++; end
            check("release handshake seen", score_valid && score_ready, 1);
            @(negedge clk);
            check("win_ready after release", win_ready, 1);
        end
        @(posedge clk); #1;
        send_win(-1, 0);
        wait_drain();

        // reload mid-window: window completes, then new descriptor
        foreach (win_val[i]) win_val[i] = i;
        send_win(1, 0);
        wait_drain();
        @(negedge clk);
        check("DESC_LOAD after reloaded window", desc_ready, 1);
        check("desc_loaded cleared by reload", desc_loaded, 0);
        check("win_ready low in DESC_LOAD", win_ready, 0);
        @(posedge clk); #1;
        foreach (desc_val[i]) desc_val[i] = 2;
        send_desc();
        send_win(-1, 0);
        wait_drain();

        // reset mid-window aborts
        drive_win_beat(0, ok);
        drive_win_beat(1, ok);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("abort score_valid", score_valid, 0);
            check("abort desc_ready", desc_ready, 1);
            check("abort desc_loaded", desc_loaded, 0);
        end
        @(posedge clk); #1;

        // randomized descriptors/windows with random backpressure and reloads
        ready_pct = 60;
        for (int r = 0; r < 6; r++) begin
            foreach (desc_val[i])
                desc_val[i] = (r == 5) ? (($urandom_range(0, 1) == 1) ? 127 : -128)
                                       : int'($urandom_range(0, 255)) - 128;
            send_desc();
            for (int w = 0; w < 4; w++) begin
                foreach (win_val[i]) win_val[i] = $urandom_range(0, 255);
                send_win((w == 3) ? int'($urandom_range(0, 2)) : -1, 2);
            end
        end
        ready_pct = 100;
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
